// File: rtl/pipe_stage_hs.sv
// Single pipeline register stage with valid/ready handshaking, optional skid
// entry for a registered in_ready, and a synchronous flush that empties it.
module pipe_stage_hs #(
  parameter int unsigned     DW       = 160,
  parameter logic [DW-1:0]   NOP_DATA = {DW{1'b0}},
  parameter bit              SKID     = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic [1:0]    occupancy
);

  // Handshake: a transfer happens on a rising edge where valid and ready are
  // both 1 and flush is 0; valid never depends on ready, data is sampled only
  // on a transfer, and flush cancels every transfer in its cycle.

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } occ_e;

  occ_e          occ_q, occ_d;
  logic [DW-1:0] main_q, main_d;
  logic [DW-1:0] skid_q, skid_d;
  logic          in_fire;
  logic          out_fire;

  assign out_valid = (occ_q != OCC_EMPTY);
  assign out_data  = out_valid ? main_q : NOP_DATA;
  assign occupancy = occ_q;

  assign in_fire  = in_valid  & in_ready  & ~flush;
  assign out_fire = out_valid & out_ready & ~flush;

  always_comb begin
    main_d = main_q;
    skid_d = skid_q;
    occ_d  = occ_q;
    if (flush) begin
      occ_d = OCC_EMPTY;
    end else begin
      case (occ_q)
        OCC_EMPTY: begin
          if (in_fire) begin
            main_d = in_data;
            occ_d  = OCC_ONE;
          end
        end
        OCC_ONE: begin
          case ({in_fire, out_fire})
            2'b11: main_d = in_data;
            2'b10: begin
              // Head stays put; the newcomer parks behind it.
              skid_d = in_data;
              occ_d  = OCC_FULL;
            end
            2'b01: occ_d = OCC_EMPTY;
            default: ;
          endcase
        end
        OCC_FULL: begin
          if (out_fire) begin
            main_d = skid_q;
            occ_d  = OCC_ONE;
          end
        end
        default: occ_d = OCC_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      occ_q  <= OCC_EMPTY;
      main_q <= NOP_DATA;
      skid_q <= NOP_DATA;
    end else begin
      occ_q  <= occ_d;
      main_q <= main_d;
      skid_q <= skid_d;
    end
  end

  generate
    if (SKID) begin : g_skid
      logic in_ready_q, in_ready_d;

      // Ready is a pure flop so upstream never sees a path from out_ready.
      assign in_ready_d = (occ_d != OCC_FULL);
      assign in_ready   = in_ready_q;

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) in_ready_q <= 1'b1;
        else      in_ready_q <= in_ready_d;
      end

      a_no_in_when_full: assert property (@(posedge clk) disable iff (!rst)
        (occ_q == OCC_FULL) |-> !in_fire);
    end else begin : g_noskid
      assign in_ready = (occ_q == OCC_EMPTY) | out_ready;

      a_never_full: assert property (@(posedge clk) disable iff (!rst)
        occ_q != OCC_FULL);
    end
  endgenerate

  a_occ_legal: assert property (@(posedge clk) disable iff (!rst)
    occ_q != 2'd3);

endmodule

// File: tb/tb_pipe_stage_hs.sv
// Directed bench for pipe_stage_hs: one SKID=1 and one SKID=0 instance (DW=32)
// sharing clock and reset, checked against hand-computed values.
module tb_pipe_stage_hs;

  localparam int unsigned DW  = 32;
  localparam logic [DW-1:0] NOP = 32'hDEAD_BEEF;

  logic clk;
  logic rst;

  logic          s1_flush, s1_in_valid, s1_in_ready, s1_out_valid, s1_out_ready;
  logic [DW-1:0] s1_in_data, s1_out_data;
  logic [1:0]    s1_occ;

  logic          s0_flush, s0_in_valid, s0_in_ready, s0_out_valid, s0_out_ready;
  logic [DW-1:0] s0_in_data, s0_out_data;
  logic [1:0]    s0_occ;

  int n_checks = 0;
  int n_fail   = 0;

  logic [DW-1:0] exp1_q[$];
  logic [DW-1:0] exp0_q[$];

  pipe_stage_hs #(.DW(DW), .NOP_DATA(NOP), .SKID(1'b1)) dut_s1 (
    .clk(clk), .rst(rst), .flush(s1_flush),
    .in_valid(s1_in_valid), .in_ready(s1_in_ready), .in_data(s1_in_data),
    .out_valid(s1_out_valid), .out_ready(s1_out_ready), .out_data(s1_out_data),
    .occupancy(s1_occ)
  );

  pipe_stage_hs #(.DW(DW), .NOP_DATA(NOP), .SKID(1'b0)) dut_s0 (
    .clk(clk), .rst(rst), .flush(s0_flush),
    .in_valid(s0_in_valid), .in_ready(s0_in_ready), .in_data(s0_in_data),
    .out_valid(s0_out_valid), .out_ready(s0_out_ready), .out_data(s0_out_data),
    .occupancy(s0_occ)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled on the falling edge.
  task automatic nxt();
    @(negedge clk);
  endtask

  task automatic s1_drive(input logic v, input logic [DW-1:0] d, input logic ordy);
    s1_in_valid  = v;
    s1_in_data   = d;
    s1_out_ready = ordy;
  endtask

  task automatic s1_expect(input string tag, input logic [1:0] occ, input logic [DW-1:0] d);
    check({tag, "_occ"},   32'(s1_occ), 32'(occ));
    check({tag, "_valid"}, 32'(s1_out_valid), 32'(occ != 2'd0));
    check({tag, "_data"},  s1_out_data, d);
  endtask

  initial begin
    rst = 1'b1;
    s1_flush = 1'b0; s0_flush = 1'b0;
    s1_drive(1'b0, '0, 1'b0);
    s0_in_valid = 1'b0; s0_in_data = '0; s0_out_ready = 1'b0;

    // Asynchronous reset, no clock edge yet
    #1 rst = 1'b0;
    #1;
    s1_expect("rst", 2'd0, NOP);
    check("rst_s1_in_ready", 32'(s1_in_ready), 32'd1);
    check("rst_s0_occ", 32'(s0_occ), 32'd0);
    check("rst_s0_data", s0_out_data, NOP);

    // Single entry right after reset release
    nxt();
    rst = 1'b1;
    s1_drive(1'b1, 32'h0000_0001, 1'b1);
    nxt();
    s1_expect("single", 2'd1, 32'h0000_0001);
    s1_drive(1'b0, 32'hBAD0_0000, 1'b1);
    nxt();
    s1_expect("single_drain", 2'd0, NOP);

    // Backpressure: A, B fill both entries, C waits upstream
    s1_drive(1'b1, 32'hA, 1'b0);
    check("bp_ready0", 32'(s1_in_ready), 32'd1);
    nxt();
    s1_expect("bp_a", 2'd1, 32'hA);
    s1_drive(1'b1, 32'hB, 1'b0);
    nxt();
    s1_expect("bp_ab", 2'd2, 32'hA);
    check("bp_full_ready", 32'(s1_in_ready), 32'd0);
    s1_drive(1'b1, 32'hC, 1'b0);
    nxt();
    s1_expect("bp_hold", 2'd2, 32'hA);
    check("bp_hold_ready", 32'(s1_in_ready), 32'd0);
    s1_drive(1'b1, 32'hC, 1'b1);
    nxt();
    s1_expect("bp_out_b", 2'd1, 32'hB);
    check("bp_ready_back", 32'(s1_in_ready), 32'd1);
    nxt();
    s1_expect("bp_out_c", 2'd1, 32'hC);
    s1_drive(1'b0, 32'h5555_AAAA, 1'b1);
    nxt();
    s1_expect("bp_empty", 2'd0, NOP);

    // Flush colliding with an input while full
    s1_drive(1'b1, 32'hD, 1'b0);
    nxt();
    s1_drive(1'b1, 32'hE, 1'b0);
    nxt();
    s1_expect("fl_full", 2'd2, 32'hD);
    s1_flush = 1'b1;
    s1_drive(1'b1, 32'hF, 1'b1);
    nxt();
    s1_expect("fl_after", 2'd0, NOP);
    check("fl_ready", 32'(s1_in_ready), 32'd1);
    s1_flush = 1'b0;
    s1_drive(1'b0, 32'hF, 1'b1);
    nxt();
    s1_expect("fl_no_f", 2'd0, NOP);

    // Async reset between edges while full, then first transfer after release
    s1_drive(1'b1, 32'h6, 1'b0);
    nxt();
    s1_drive(1'b1, 32'h7, 1'b0);
    nxt();
    s1_expect("ar_full", 2'd2, 32'h6);
    s1_drive(1'b0, 32'h0, 1'b0);
    #2 rst = 1'b0;
    #1;
    s1_expect("ar_now", 2'd0, NOP);
    check("ar_ready", 32'(s1_in_ready), 32'd1);
    nxt();
    rst = 1'b1;
    s1_drive(1'b1, 32'h9, 1'b0);
    nxt();
    s1_expect("ar_first", 2'd1, 32'h9);
    s1_drive(1'b0, 32'h0, 1'b1);
    nxt();
    s1_expect("ar_drain", 2'd0, NOP);

    // SKID=0: in_ready follows out_ready combinationally when holding one entry
    s0_in_valid = 1'b1; s0_in_data = 32'h0000_00AB; s0_out_ready = 1'b0;
    #1 check("s0_ready_empty", 32'(s0_in_ready), 32'd1);
    nxt();
    check("s0_occ1", 32'(s0_occ), 32'd1);
    check("s0_data", s0_out_data, 32'h0000_00AB);
    check("s0_ready_lo", 32'(s0_in_ready), 32'd0);
    s0_in_valid = 1'b0; s0_in_data = 32'hFFFF_FFFF;
    s0_out_ready = 1'b1;
    #1 check("s0_ready_up", 32'(s0_in_ready), 32'd1);
    s0_out_ready = 1'b0;
    #1 check("s0_ready_dn", 32'(s0_in_ready), 32'd0);
    s0_out_ready = 1'b1;
    #1 check("s0_ready_up2", 32'(s0_in_ready), 32'd1);
    nxt();
    check("s0_drained", 32'(s0_occ), 32'd0);
    check("s0_nop", s0_out_data, NOP);

    // Streaming, both variants, 100 back-to-back transfers
    for (int i = 0; i <= 100; i++) begin
      if (i > 0) begin
        check("st1_valid", 32'(s1_out_valid), 32'd1);
        check("st1_occ", 32'(s1_occ), 32'd1);
        check("st1_data", s1_out_data, exp1_q.pop_front());
        check("st0_valid", 32'(s0_out_valid), 32'd1);
        check("st0_occ", 32'(s0_occ), 32'd1);
        check("st0_data", s0_out_data, exp0_q.pop_front());
      end
      if (i < 100) begin
        s1_drive(1'b1, 32'h1000_0000 + 32'(i * 3), 1'b1);
        exp1_q.push_back(32'h1000_0000 + 32'(i * 3));
        s0_in_valid = 1'b1; s0_out_ready = 1'b1;
        s0_in_data  = 32'h2000_0000 ^ 32'(i * 7);
        exp0_q.push_back(32'h2000_0000 ^ 32'(i * 7));
      end else begin
        s1_drive(1'b0, '0, 1'b1);
        s0_in_valid = 1'b0;
      end
      nxt();
    end
    check("st1_end_occ", 32'(s1_occ), 32'd0);
    check("st0_end_occ", 32'(s0_occ), 32'd0);
    check("st_q_left", 32'(exp1_q.size() + exp0_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
